// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared constants, state encoding and field helpers for fp_div_seq
package fp_div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_NORM = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int          FP_BIAS    = 127;
  localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
  localparam logic [30:0] FP_INF_MAG = 31'h7F80_0000;
  localparam int          ITER_N     = 25;

  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction

  function automatic logic [7:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction

  // Hidden bit always set; exponent-zero operands are classified as zero elsewhere.
  function automatic logic [23:0] fp_man(input logic [31:0] x);
    return {1'b1, x[22:0]};
  endfunction

endpackage

// File: rtl/fp_div_seq_if.sv
// rtl/fp_div_seq_if.sv - operand/result handshake bundle between issue logic and the divider
interface fp_div_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        div_zero;
  logic        invalid;
  logic        overflow;
  logic        underflow;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, div_zero, invalid, overflow, underflow
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, result, div_zero, invalid, overflow, underflow
  );
endinterface

// File: rtl/fp_div_step.sv
// rtl/fp_div_step.sv - one combinational restoring-division step on the 26-bit remainder
module fp_div_step (
  input  logic [25:0] r_i,
  input  logic [23:0] mb_i,
  output logic [25:0] r_o,
  output logic        q_o
);

  logic [25:0] diff;

  always_comb begin
    q_o  = (r_i >= {2'b00, mb_i});
    diff = q_o ? (r_i - {2'b00, mb_i}) : r_i;
    // diff < mb < 2^24, so the shift never loses a set bit
    r_o  = diff << 1;
  end

endmodule

// File: rtl/fp_div_seq.sv
// rtl/fp_div_seq.sv - sequential single-precision divider: special cases at accept, 25-step restoring mantissa divide
module fp_div_seq (
  input  logic         clk,
  input  logic         rst_n,
  fp_div_seq_if.slave  bus
);
  import fp_div_pkg::*;

  logic [1:0]  state_q, state_d;
  logic        rdy_q;
  logic [4:0]  cnt_q, cnt_d;
  logic [25:0] r_q, r_d;
  logic [23:0] mb_q, mb_d;
  logic [24:0] q_q, q_d;
  logic        sign_q, sign_d;
  logic [7:0]  ea_q, ea_d, eb_q, eb_d;
  logic [31:0] result_q, result_d;
  logic        dz_q, dz_d, inv_q, inv_d, ovf_q, ovf_d, unf_q, unf_d;

  logic [25:0] step_r;
  logic        step_q;

  logic [7:0]  a_exp, b_exp;
  logic [23:0] a_man, b_man;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic        accept, sign_in;

  logic signed [9:0] e_norm;
  logic [22:0]       man_norm;

  fp_div_step u_step (
    .r_i  (r_q),
    .mb_i (mb_q),
    .r_o  (step_r),
    .q_o  (step_q)
  );

  always_comb begin
    a_exp   = fp_exp(bus.op_a);
    b_exp   = fp_exp(bus.op_b);
    a_man   = fp_man(bus.op_a);
    b_man   = fp_man(bus.op_b);
    sign_in = fp_sign(bus.op_a) ^ fp_sign(bus.op_b);
    a_zero  = (a_exp == 8'd0);
    b_zero  = (b_exp == 8'd0);
    a_inf   = (a_exp == 8'hFF) && (a_man[22:0] == 23'd0);
    b_inf   = (b_exp == 8'hFF) && (b_man[22:0] == 23'd0);
    a_nan   = (a_exp == 8'hFF) && (a_man[22:0] != 23'd0);
    b_nan   = (b_exp == 8'hFF) && (b_man[22:0] != 23'd0);
    accept  = bus.in_valid && rdy_q && (state_q == ST_IDLE);
  end

  // q[24] set means the quotient landed in [2^24, 2^25) and carries one extra exponent step.
  always_comb begin
    e_norm   = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q})
             + 10'(FP_BIAS - 1) + $signed({9'd0, q_q[24]});
    man_norm = q_q[24] ? q_q[23:1] : q_q[22:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    mb_d     = mb_q;
    q_d      = q_q;
    sign_d   = sign_q;
    ea_d     = ea_q;
    eb_d     = eb_q;
    result_d = result_q;
    dz_d     = dz_q;
    inv_d    = inv_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          sign_d = sign_in;
          ea_d   = a_exp;
          eb_d   = b_exp;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            result_d = FP_QNAN;
            inv_d    = 1'b1;
            state_d  = ST_DONE;
          end else if (b_zero) begin
            result_d = {sign_in, FP_INF_MAG};
            dz_d     = !a_inf;
            state_d  = ST_DONE;
          end else if (a_inf) begin
            result_d = {sign_in, FP_INF_MAG};
            state_d  = ST_DONE;
          end else if (a_zero || b_inf) begin
            result_d = {sign_in, 31'd0};
            state_d  = ST_DONE;
          end else begin
            r_d     = {2'b00, a_man};
            mb_d    = b_man;
            q_d     = '0;
            cnt_d   = 5'(ITER_N - 1);
            state_d = ST_ITER;
          end
        end
      end

      ST_ITER: begin
        r_d = step_r;
        q_d = {q_q[23:0], step_q};
        if (cnt_q == 5'd0) begin
          state_d = ST_NORM;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      ST_NORM: begin
        state_d = ST_DONE;
        if (e_norm >= 10'sd255) begin
          result_d = {sign_q, FP_INF_MAG};
          ovf_d    = 1'b1;
        end else if (e_norm <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
          unf_d    = 1'b1;
        end else begin
          result_d = {sign_q, e_norm[7:0], man_norm};
        end
      end

      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          dz_d    = 1'b0;
          inv_d   = 1'b0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rdy_q    <= 1'b0;
      cnt_q    <= '0;
      r_q      <= '0;
      mb_q     <= '0;
      q_q      <= '0;
      sign_q   <= 1'b0;
      ea_q     <= '0;
      eb_q     <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
      inv_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_q    <= 1'b1;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      mb_q     <= mb_d;
      q_q      <= q_d;
      sign_q   <= sign_d;
      ea_q     <= ea_d;
      eb_q     <= eb_d;
      result_q <= result_d;
      dz_q     <= dz_d;
      inv_q    <= inv_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // rdy_q keeps in_ready low for as long as reset is held, even though state is already IDLE.
  assign bus.in_ready  = rdy_q && (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.div_zero  = dz_q;
  assign bus.invalid   = inv_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb/tb_fp_div_seq.sv - directed self-checking bench for fp_div_seq
module tb_fp_div_seq;

  localparam logic [31:0] F_NONE = 32'd0;
  localparam logic [31:0] F_INV  = 32'd8;
  localparam logic [31:0] F_DZ   = 32'd4;
  localparam logic [31:0] F_OVF  = 32'd2;
  localparam logic [31:0] F_UNF  = 32'd1;

  logic clk = 1'b0;
  logic rst_n;

  fp_div_seq_if dif ();

  fp_div_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags_now();
    return {28'd0, dif.invalid, dif.div_zero, dif.overflow, dif.underflow};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (!dif.in_ready && w < 60) begin
      @(negedge clk);
      w++;
    end
    check_val("issue_in_ready", 32'(dif.in_ready), 32'd1);
    dif.op_a     = a;
    dif.op_b     = b;
    dif.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dif.in_valid = 1'b0;
  endtask

  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic [31:0] exp_flags, input int exp_lat);
    int lat;
    issue(a, b);
    lat = 1;
    while (!dif.out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_lat"},   32'(lat), 32'(exp_lat));
    check_val({tag, "_res"},   dif.result, exp_res);
    check_val({tag, "_flags"}, flags_now(), exp_flags);
  endtask

  task automatic take_result(input string tag);
    dif.out_ready = 1'b1;
    @(negedge clk);
    dif.out_ready = 1'b0;
    check_val({tag, "_vld_clr"},  32'(dif.out_valid), 32'd0);
    check_val({tag, "_flg_clr"},  flags_now(), F_NONE);
    check_val({tag, "_rdy_back"}, 32'(dif.in_ready), 32'd1);
  endtask

  initial begin
    rst_n         = 1'b0;
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b0;
    dif.op_a      = '0;
    dif.op_b      = '0;
    repeat (3) @(negedge clk);
    check_val("rst_in_ready",  32'(dif.in_ready), 32'd0);
    check_val("rst_out_valid", 32'(dif.out_valid), 32'd0);
    check_val("rst_result",    dif.result, 32'd0);
    check_val("rst_flags",     flags_now(), F_NONE);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("post_rst_in_ready", 32'(dif.in_ready), 32'd1);

    run_div("six_by_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 27);
    take_result("six_by_two");
    run_div("one_third",  32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, F_NONE, 27);
    take_result("one_third");
    run_div("neg_six",    32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, F_NONE, 27);
    take_result("neg_six");
    run_div("div_zero",   32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, F_DZ,   1);
    take_result("div_zero");
    run_div("zero_zero",  32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, F_INV,  1);
    take_result("zero_zero");
    run_div("nan_in",     32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, F_INV,  1);
    take_result("nan_in");
    run_div("inf_inf",    32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, F_INV,  1);
    take_result("inf_inf");
    run_div("inf_num",    32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, F_NONE, 1);
    take_result("inf_num");
    run_div("num_inf",    32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, F_NONE, 1);
    take_result("num_inf");
    run_div("negzero",    32'h8000_0000, 32'h4000_0000, 32'h8000_0000, F_NONE, 1);
    take_result("negzero");
    run_div("overflow",   32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, F_OVF,  27);
    take_result("overflow");
    run_div("underflow",  32'h0080_0000, 32'h4000_0000, 32'h0000_0000, F_UNF,  27);
    take_result("underflow");

    run_div("bp", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 27);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        dif.op_a     = 32'h3F80_0000;
        dif.op_b     = 32'h0000_0000;
        dif.in_valid = 1'b1;
      end else begin
        dif.in_valid = 1'b0;
      end
      @(negedge clk);
      check_val("bp_hold_valid", 32'(dif.out_valid), 32'd1);
      check_val("bp_hold_res",   dif.result, 32'h4040_0000);
      check_val("bp_hold_flags", flags_now(), F_NONE);
      check_val("bp_in_ready",   32'(dif.in_ready), 32'd0);
    end
    dif.in_valid = 1'b0;
    take_result("bp");
    repeat (3) begin
      @(negedge clk);
      check_val("bp_no_ghost", 32'(dif.out_valid), 32'd0);
    end

    issue(32'h40C0_0000, 32'h4000_0000);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("midrst_out_valid", 32'(dif.out_valid), 32'd0);
    check_val("midrst_in_ready",  32'(dif.in_ready), 32'd0);
    @(negedge clk);
    check_val("midrst_in_ready_hold", 32'(dif.in_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("midrst_in_ready_back", 32'(dif.in_ready), 32'd1);
    repeat (20) begin
      @(negedge clk);
      check_val("midrst_no_result", 32'(dif.out_valid), 32'd0);
    end
    run_div("after_rst", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, F_NONE, 27);
    take_result("after_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
